// File: rtl/decode_pkg.sv
// Shared decode-stage types: opcodes, extender/ALU/result selects and the ID/EX control bundle.
package decode_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        result_src_t result_src;
        logic        alu_src;
        logic        branch;
        logic        jump;
        alu_ctrl_t   alu_ctrl;
        logic        illegal;
    } ctrl_t;

    // Unknown funct3 falls back to add; sub only exists for R-type.
    function automatic alu_ctrl_t alu_dec(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b010:  alu_dec = ALU_SLT;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_main_decoder.sv
// Combinational opcode decoder: produces the control bundle and immediate select for ID.
module main_decoder
    import decode_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_t      ctrl,
    output imm_src_t   imm_src
);

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        case (op)
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_SW: begin
                imm_src        = IMM_S;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_dec(funct3, funct7b5);
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_dec(funct3, 1'b0);
            end
            OP_BEQ: begin
                imm_src       = IMM_B;
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                imm_src         = IMM_J;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: decode, load-use hazard detection, branch flush and the ID/EX control register.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] InstrD,
    input  logic             PCSrcE,
    output logic [1:0]       ImmSrcD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             BranchE,
    output logic             JumpE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [4:0]       RdE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic             IllegalE
);

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e;
    imm_src_t   imm_src_d;
    logic [4:0] rd_d, rs1_d, rs2_d;
    logic       lw_stall;
    logic       bubble;
    logic       unused_bits;

    assign rd_d        = InstrD[11:7];
    assign rs1_d       = InstrD[19:15];
    assign rs2_d       = InstrD[24:20];
    assign unused_bits = ^{InstrD[WIDTH-1:31], InstrD[29:25]};

    main_decoder u_main_decoder (
        .op       (InstrD[6:0]),
        .funct3   (InstrD[14:12]),
        .funct7b5 (InstrD[30]),
        .ctrl     (ctrl_d),
        .imm_src  (imm_src_d)
    );

    // rs2 is compared even for instructions that do not read it; a spare stall is harmless.
    assign lw_stall = (ctrl_e.result_src == RES_MEM) && (RdE != 5'd0) &&
                      ((RdE == rs1_d) || (RdE == rs2_d));
    assign bubble   = PCSrcE || lw_stall;

    assign ImmSrcD = imm_src_d;
    assign StallF  = !rst && lw_stall && !PCSrcE;
    assign StallD  = StallF;
    assign FlushD  = !rst && PCSrcE;
    assign FlushE  = !rst && bubble;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ctrl_e <= '0;
            RdE    <= '0;
            Rs1E   <= '0;
            Rs2E   <= '0;
        end else begin
            ctrl_e <= ctrl_d;
            RdE    <= rd_d;
            Rs1E   <= rs1_d;
            Rs2E   <= rs2_d;
        end
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ResultSrcE  = ctrl_e.result_src;
    assign ALUControlE = ctrl_e.alu_ctrl;
    assign IllegalE    = ctrl_e.illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: per-cycle comparison against a table-driven model plus literal checks.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic        PCSrcE;
    logic [1:0]  ImmSrcD;
    logic        StallF, StallD, FlushD, FlushE;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE, Rs1E, Rs2E;
    logic        IllegalE;

    decode_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCSrcE(PCSrcE), .ImmSrcD(ImmSrcD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       rw, mw, as, br, jp, il;
        bit [1:0] rs;
        bit [2:0] alu;
        bit [4:0] rd, r1, r2;
    } ex_t;

    int  nvec  = 0;
    int  nfail = 0;
    ex_t exp_e;
    bit  mvalid = 1'b0;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] SW    = 32'h0051A423;
    localparam logic [31:0] LW5   = 32'h00012283;
    localparam logic [31:0] ADD6  = 32'h00128333;
    localparam logic [31:0] LW0   = 32'h00012003;
    localparam logic [31:0] ADD0  = 32'h00000333;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] SUB6  = 32'h40128333;
    localparam logic [31:0] OR6   = 32'h0012E333;
    localparam logic [31:0] AND6  = 32'h0012F333;
    localparam logic [31:0] SLT6  = 32'h0012A333;
    localparam logic [31:0] RF1   = 32'h00129333;
    localparam logic [31:0] ADDIX = 32'h40128313;
    localparam logic [31:0] ANDI  = 32'h0FF2F313;
    localparam logic [31:0] JAL1  = 32'h000000EF;
    localparam logic [31:0] BEQ   = 32'h00128063;

    function automatic bit [2:0] alu_of(bit [2:0] f3, bit sub);
        if (f3 == 3'd0) return sub ? 3'd1 : 3'd0;
        if (f3 == 3'd7) return 3'd2;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd2) return 3'd5;
        return 3'd0;
    endfunction

    function automatic ex_t model_decode(bit [31:0] i);
        ex_t e = '0;
        e.rd = i[11:7]; e.r1 = i[19:15]; e.r2 = i[24:20];
        case (i[6:0])
            7'h03: begin e.rw = 1; e.as = 1; e.rs = 2'd1; end
            7'h23: begin e.mw = 1; e.as = 1; end
            7'h33: begin e.rw = 1; e.alu = alu_of(i[14:12], i[30]); end
            7'h13: begin e.rw = 1; e.as = 1; e.alu = alu_of(i[14:12], 1'b0); end
            7'h63: begin e.br = 1; e.alu = 3'd1; end
            7'h6F: begin e.rw = 1; e.jp = 1; e.rs = 2'd2; end
            default: e.il = 1;
        endcase
        return e;
    endfunction

    function automatic bit [1:0] model_imm(bit [31:0] i);
        case (i[6:0])
            7'h23:   return 2'd1;
            7'h63:   return 2'd2;
            7'h6F:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit model_hazard(ex_t e, bit [31:0] i);
        return (e.rs == 2'd1) && (e.rd != 0) && (e.rd == i[19:15] || e.rd == i[24:20]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: next expected ID/EX contents from the current inputs.
    always @(posedge clk) begin
        if (rst) begin
            exp_e  <= '0;
            mvalid <= 1'b1;
        end else if (PCSrcE || model_hazard(exp_e, InstrD)) begin
            exp_e <= '0;
        end else begin
            exp_e <= model_decode(InstrD);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            bit hz, st;
            hz = !rst && model_hazard(exp_e, InstrD);
            st = hz && !PCSrcE;
            check("ImmSrcD",     ImmSrcD,     model_imm(InstrD));
            check("StallF",      StallF,      st);
            check("StallD",      StallD,      st);
            check("FlushD",      FlushD,      !rst && PCSrcE);
            check("FlushE",      FlushE,      !rst && (PCSrcE || hz));
            check("RegWriteE",   RegWriteE,   exp_e.rw);
            check("MemWriteE",   MemWriteE,   exp_e.mw);
            check("ALUSrcE",     ALUSrcE,     exp_e.as);
            check("BranchE",     BranchE,     exp_e.br);
            check("JumpE",       JumpE,       exp_e.jp);
            check("ResultSrcE",  ResultSrcE,  exp_e.rs);
            check("ALUControlE", ALUControlE, exp_e.alu);
            check("RdE",         RdE,         exp_e.rd);
            check("Rs1E",        Rs1E,        exp_e.r1);
            check("Rs2E",        Rs2E,        exp_e.r2);
            check("IllegalE",    IllegalE,    exp_e.il);
        end
    end

    task automatic drive(input logic [31:0] i, input logic pc, input logic r);
        @(posedge clk);
        #1;
        InstrD = i; PCSrcE = pc; rst = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; InstrD = NOP; PCSrcE = 1'b0;
        drive(NOP, 0, 1);
        check("rst_RegWriteE", RegWriteE, 0);
        check("rst_RdE", RdE, 0);
        check("rst_StallF", StallF, 0);

        drive(SW, 0, 0);
        check("sw_ImmSrcD", ImmSrcD, 2'b01);
        drive(NOP, 0, 0);
        check("sw_MemWriteE", MemWriteE, 1);
        check("sw_ALUSrcE", ALUSrcE, 1);
        check("sw_RegWriteE", RegWriteE, 0);
        check("sw_Rs1E", Rs1E, 3);
        check("sw_Rs2E", Rs2E, 5);

        drive(LW5, 0, 0);
        drive(ADD6, 0, 0);
        check("lu_StallF", StallF, 1);
        check("lu_StallD", StallD, 1);
        check("lu_FlushE", FlushE, 1);
        drive(ADD6, 0, 0);
        check("lu_bubble_RegWriteE", RegWriteE, 0);
        check("lu_bubble_ResultSrcE", ResultSrcE, 0);
        check("lu_nostall", StallF, 0);
        drive(NOP, 0, 0);
        check("lu_RdE", RdE, 6);
        check("lu_ALUControlE", ALUControlE, 3'b000);
        check("lu_RegWriteE", RegWriteE, 1);

        drive(LW0, 0, 0);
        drive(ADD0, 0, 0);
        check("x0_StallF", StallF, 0);
        check("x0_FlushE", FlushE, 0);

        drive(LW5, 0, 0);
        drive(ADD6, 1, 0);
        check("br_FlushD", FlushD, 1);
        check("br_FlushE", FlushE, 1);
        check("br_StallF", StallF, 0);
        drive(NOP, 0, 0);
        check("br_RegWriteE", RegWriteE, 0);
        check("br_RdE", RdE, 0);

        drive(ILL, 0, 0);
        check("ill_ImmSrcD", ImmSrcD, 2'b00);
        drive(NOP, 0, 0);
        check("ill_IllegalE", IllegalE, 1);
        check("ill_RegWriteE", RegWriteE, 0);
        check("ill_ALUSrcE", ALUSrcE, 0);

        drive(LW5, 0, 0);
        drive(ADD6, 0, 1);
        check("rstmid_StallF", StallF, 0);
        check("rstmid_FlushE", FlushE, 0);
        drive(ADD6, 0, 0);
        check("rstmid_ResultSrcE", ResultSrcE, 0);
        check("rstmid_StallF2", StallF, 0);

        drive(JAL1, 0, 0);
        check("jal_ImmSrcD", ImmSrcD, 2'b11);
        drive(BEQ, 0, 0);
        check("beq_ImmSrcD", ImmSrcD, 2'b10);
        check("jal_ResultSrcE", ResultSrcE, 2'b10);
        drive(SUB6, 0, 0);
        check("beq_ALUControlE", ALUControlE, 3'b001);
        drive(OR6, 0, 0);
        check("sub_ALUControlE", ALUControlE, 3'b001);
        drive(AND6, 0, 0);
        drive(SLT6, 0, 0);
        drive(RF1, 0, 0);
        check("slt_ALUControlE", ALUControlE, 3'b101);
        drive(ADDIX, 0, 0);
        check("rf1_ALUControlE", ALUControlE, 3'b000);
        drive(ANDI, 0, 0);
        check("addix_ALUControlE", ALUControlE, 3'b000);
        drive(LW5, 0, 0);
        check("andi_ALUControlE", ALUControlE, 3'b010);
        drive(LW5, 0, 0);
        drive(LW5, 0, 0);
        drive(NOP, 0, 0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Decode-stage pipeline controller for the five-stage RV32I core. Decodes the instruction in ID into the control bundle, drives `ImmSrcD` to the immediate extender, and registers the bundle into the ID/EX control register. It also detects load-use hazards and applies branch/jump flushes, producing the stall and flush signals for the IF/ID register and the bubble for ID/EX.

## Interface
Parameters:
- `WIDTH`, 32: instruction width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `InstrD` in WIDTH: instruction currently in ID.
- `PCSrcE` in 1: taken branch or jump resolved in EX this cycle.
- `ImmSrcD` out 2: extender select: 00 I, 01 S, 10 B, 11 J. Combinational.
- `StallF`, `StallD` out 1 each: hold PC and IF/ID. Combinational.
- `FlushD`, `FlushE` out 1 each: squash IF/ID, bubble ID/EX. Combinational.
- `RegWriteE`, `MemWriteE`, `ALUSrcE`, `BranchE`, `JumpE` out 1 each: registered EX controls.
- `ResultSrcE` out 2: registered. 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE` out 3: registered. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RdE`, `Rs1E`, `Rs2E` out 5 each: registered register indices.
- `IllegalE` out 1: registered. The EX instruction had an unsupported opcode.

## Operation
Decode table, keyed on `InstrD[6:0]`:
- `0000011` lw: ImmSrc 00, RegWrite, ALUSrc, ResultSrc 01, ALU add.
- `0100011` sw: ImmSrc 01, MemWrite, ALUSrc, ALU add.
- `0110011` R-type: RegWrite. ALU op from funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
- `0010011` I-ALU: ImmSrc 00, RegWrite, ALUSrc. ALU op from funct3; funct7[5] is ignored, so no subi.
- `1100011` beq: ImmSrc 10, Branch, ALU sub.
- `1101111` jal: ImmSrc 11, RegWrite, Jump, ResultSrc 10.
- Any other opcode: all controls 0, ImmSrc 00, IllegalE set when the instruction is latched.
- Unsupported funct3 within a supported opcode: ALU add, no illegal flag.

Register indices are `Rd = InstrD[11:7]`, `Rs1 = InstrD[19:15]`, `Rs2 = InstrD[24:20]`.

Load-use hazard:
- `lwStall = (ResultSrcE == 01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D)`.
- The comparison uses raw fields regardless of whether the D instruction actually reads rs2 (conservative by design).

Next-state for the ID/EX register, in priority order:
1. `rst`: all E outputs 0.
2. `PCSrcE`: bubble, all E outputs 0.
3. `lwStall`: bubble.
4. Otherwise: load the decoded bundle from D.

Stall and flush outputs:
- `StallF = StallD = lwStall && !PCSrcE`.
- `FlushD = PCSrcE`.
- `FlushE = PCSrcE || lwStall`.
- During `rst`, all four are 0.

## Timing
- `ImmSrcD` and the stall/flush outputs are combinational, valid in the same cycle as `InstrD`, `PCSrcE` and the E registers.
- E outputs have 1-cycle latency: the value seen after edge n reflects the instruction in D before edge n.
- Reset value of every registered output is 0, which is a NOP bubble. Reset asserted mid-stall clears the E registers at the next edge; the stall then drops because `ResultSrcE` becomes 00.
- Load-use inserts exactly one bubble:
  - Cycle n: stall and bubble asserted.
  - Cycle n+1: `ResultSrcE = 00`, so no stall; the dependent instruction latches normally.
- `PCSrcE` coinciding with `lwStall`: the flush wins and no stall is asserted, because the D instruction is squashed.
- Back-to-back loads feeding each other stall once per dependent pair.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams;
  - the `imm_src_t` enum (I/S/B/J), which the immediate extender also uses;
  - the `alu_ctrl_t` enum;
  - the `result_src_t` enum;
  - a packed `ctrl_t` struct (RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, Jump, ALUControl, Illegal).
- One combinational sub-module, `main_decoder`, maps opcode/funct3/funct7[5] to `ctrl_t` and ImmSrc.
- The top level instantiates `main_decoder` and owns the hazard logic and the ID/EX register.

## Test plan
- Reset mid-run: assert `rst` for 1 cycle with an R-type in D → all E outputs 0 and all stall/flush outputs 0 after the edge.
- sw (`InstrD = 32'h0051A423`) → `ImmSrcD = 01` same cycle. Next edge: `MemWriteE = 1`, `ALUSrcE = 1`, `RegWriteE = 0`, `Rs1E = 3`, `Rs2E = 5`.
- lw x5 followed by add x6,x5,x1:
  - cycle 1: `StallF = StallD = FlushE = 1`;
  - cycle 2: E holds a bubble and no stall;
  - cycle 3: `RdE = 6`, `ALUControlE = 000`.
- lw x0 followed by add using x0 → no stall, `FlushE = 0`.
- beq in EX with `PCSrcE = 1` while a dependent-load condition also holds → `FlushD = FlushE = 1`, `StallF = 0`; E is zeroed next cycle.
- `InstrD` opcode `1111111` → `ImmSrcD = 00`. Next edge: `IllegalE = 1` and all other controls 0.
